// File: rtl/seg7_scan_driver_if.sv
// seg7_scan_driver_if
// Bundles the digit-load strobe and the display pins of seg7_scan_driver.
//
// Load semantics: 'load' is a single-cycle capture strobe. There is no ready.
// The driver samples bcd_in/dp_in on every clock edge where load=1, so the
// source holds load high for exactly the cycles whose data it wants captured.
// Display outputs (seg, dp, an, frame_tick) are registered and active-low,
// except frame_tick, which is an active-high one-cycle pulse.
interface seg7_scan_driver_if;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        frame_tick;

    // Source side: supplies digits, observes the display pins
    modport master (
        output load, bcd_in, dp_in,
        input  seg, dp, an, frame_tick
    );

    // Driver side: the scan driver itself
    modport slave (
        input  load, bcd_in, dp_in,
        output seg, dp, an, frame_tick
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
// Time-multiplexes four BCD digits with decimal points onto a 4-digit
// common-anode seven-segment display. The input is double-buffered: a
// pending buffer takes loads, and the active buffer it feeds is updated only
// at frame boundaries, so a frame never mixes old and new digits. Each digit
// slot starts with DEAD_CYCLES of all-anodes-off to suppress ghosting.
//
// Optional feature: define LEADING_ZERO_BLANK_EN to blank leading zero
// digits 3..1 (digit 0 is always shown).
module seg7_scan_driver #(
    parameter int REFRESH_DIV = 100000,
    parameter int DEAD_CYCLES = 1000
) (
    input  logic                clk,
    input  logic                reset,
    seg7_scan_driver_if.slave   bus
);

    localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] C_DEAD = CW'(DEAD_CYCLES);

    // Slot timing state
    logic [CW-1:0] r_cnt;
    logic [1:0]    r_idx;

    // Pending and active digit buffers
    logic [15:0]   r_pend_bcd;
    logic [3:0]    r_pend_dp;
    logic          r_pend;
    logic [15:0]   r_act_bcd;
    logic [3:0]    r_act_dp;

    // Registered pin drivers
    logic [6:0]    r_seg;
    logic          r_dp;
    logic [3:0]    r_an;
    logic          r_frame_tick;

    logic          w_wrap;
    logic          w_frame;
    logic          w_dead;
    logic          w_blank;
    logic [3:0]    w_digit;
    logic          w_dp_req;

    // Segment pattern {g,f,e,d,c,b,a}, active-low; non-decimal codes show a dash
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    assign w_wrap   = (r_cnt == C_LAST);
    assign w_frame  = w_wrap && (r_idx == 2'd3);
    assign w_dead   = (r_cnt < C_DEAD);
    assign w_digit  = r_act_bcd[{r_idx, 2'b00} +: 4];
    assign w_dp_req = r_act_dp[r_idx];

`ifdef LEADING_ZERO_BLANK_EN
    logic [3:0] w_zero;
    logic [3:0] w_blank_vec;

    // A digit is blanked when it and every digit to its left are zero
    always_comb begin
        w_zero[0] = (r_act_bcd[3:0]   == 4'd0);
        w_zero[1] = (r_act_bcd[7:4]   == 4'd0);
        w_zero[2] = (r_act_bcd[11:8]  == 4'd0);
        w_zero[3] = (r_act_bcd[15:12] == 4'd0);
        w_blank_vec[3] = w_zero[3];
        w_blank_vec[2] = w_zero[3] & w_zero[2];
        w_blank_vec[1] = w_zero[3] & w_zero[2] & w_zero[1];
        w_blank_vec[0] = 1'b0;
    end

    assign w_blank = w_blank_vec[r_idx];
`else
    assign w_blank = 1'b0;
`endif

    // Slot counter and digit index; index advances when the slot counter wraps
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_idx <= 2'd0;
        end else if (w_wrap) begin
            r_cnt <= '0;
            r_idx <= r_idx + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Double buffer: loads land in pending; active changes only at frame boundaries
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pend_bcd <= '0;
            r_pend_dp  <= '0;
            r_pend     <= 1'b0;
            r_act_bcd  <= '0;
            r_act_dp   <= '0;
        end else if (w_frame && bus.load) begin
            // A load coinciding with the boundary bypasses pending so it shows this frame
            r_act_bcd  <= bus.bcd_in;
            r_act_dp   <= bus.dp_in;
            r_pend     <= 1'b0;
        end else if (w_frame && r_pend) begin
            r_act_bcd  <= r_pend_bcd;
            r_act_dp   <= r_pend_dp;
            r_pend     <= 1'b0;
        end else if (bus.load) begin
            r_pend_bcd <= bus.bcd_in;
            r_pend_dp  <= bus.dp_in;
            r_pend     <= 1'b1;
        end
    end

    // Pin registers: one clock behind the slot state; off during dead time or blanking
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_an         <= 4'b1111;
            r_seg        <= 7'b1111111;
            r_dp         <= 1'b1;
            r_frame_tick <= 1'b0;
        end else begin
            r_frame_tick <= w_frame;
            if (w_dead || w_blank) begin
                r_an  <= 4'b1111;
                r_seg <= 7'b1111111;
                r_dp  <= 1'b1;
            end else begin
                r_an  <= ~(4'b0001 << r_idx);
                r_seg <= f_decode(w_digit);
                r_dp  <= ~w_dp_req;
            end
        end
    end

    assign bus.an         = r_an;
    assign bus.seg        = r_seg;
    assign bus.dp         = r_dp;
    assign bus.frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver
// Runs seg7_scan_driver with REFRESH_DIV=8, DEAD_CYCLES=2 against a reference
// model that derives the expected pins from the cycle number since reset
// release (slot = cycle/8 mod 4, position = cycle mod 8) and a record of the
// digits currently on display. Loads awaiting the next frame sit in pend_q;
// the newest entry is the one that reaches the display.
// Define LEADING_ZERO_BLANK_EN to build with leading-zero blanking.
module tb_seg7_scan_driver;

    localparam int RD    = 8;
    localparam int DC    = 2;
    localparam int FRAME = 4 * RD;

    localparam logic [6:0] SEG_TAB [0:15] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0111111, 7'b0111111,
        7'b0111111, 7'b0111111, 7'b0111111, 7'b0111111
    };

    // ---------------- clock / reset ----------------
    logic clk;
    logic reset;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    seg7_scan_driver_if bus ();

    seg7_scan_driver #(
        .REFRESH_DIV (RD),
        .DEAD_CYCLES (DC)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // ---------------- scoreboard / model state ----------------
    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc      = 0;
    logic [19:0] pend_q[$];
    logic [15:0] m_bcd;
    logic [3:0]  m_dp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s (cycle %0d): got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Expected pins for the state during cycle c
    function automatic void model_out(input int c, output logic [3:0] e_an,
                                      output logic [6:0] e_seg, output logic e_dp);
        int  slot;
        int  pos;
        int  dig;
        bit  blank;
        slot  = (c / RD) % 4;
        pos   = c % RD;
        dig   = int'((m_bcd >> (4 * slot)) & 16'hF);
        blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
        if (slot != 0) begin
            blank = 1'b1;
            for (int j = slot; j < 4; j++)
                if (((m_bcd >> (4 * j)) & 16'hF) != 0) blank = 1'b0;
        end
`endif
        if (pos < DC || blank) begin
            e_an  = 4'b1111;
            e_seg = 7'b1111111;
            e_dp  = 1'b1;
        end else begin
            e_an  = 4'b1111 & ~(4'b0001 << slot);
            e_seg = SEG_TAB[dig];
            e_dp  = ~m_dp[slot];
        end
    endfunction

    function automatic void model_reset();
        m_bcd = '0;
        m_dp  = '0;
        pend_q.delete();
        cyc = 0;
    endfunction

    // ---------------- driver tasks ----------------
    // One clock: predict pins, advance model buffers, then compare after the edge
    task automatic tick();
        logic [3:0] e_an;
        logic [6:0] e_seg;
        logic       e_dp;
        logic       e_ft;
        logic [19:0] w;
        model_out(cyc, e_an, e_seg, e_dp);
        e_ft = ((cyc % FRAME) == FRAME - 1);
        if ((cyc % FRAME) == FRAME - 1) begin
            if (bus.load) begin
                m_bcd = bus.bcd_in;
                m_dp  = bus.dp_in;
            end else if (pend_q.size() > 0) begin
                w     = pend_q[$];
                m_bcd = w[15:0];
                m_dp  = w[19:16];
            end
            pend_q.delete();
        end else if (bus.load) begin
            pend_q.push_back({bus.dp_in, bus.bcd_in});
        end
        @(posedge clk);
        #1;
        check("an", 32'(bus.an), 32'(e_an));
        check("seg", 32'(bus.seg), 32'(e_seg));
        check("dp", 32'(bus.dp), 32'(e_dp));
        check("frame_tick", 32'(bus.frame_tick), 32'(e_ft));
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Run until the next cycle to be simulated sits at frame phase p
    task automatic run_to(input int p);
        while ((cyc % FRAME) != p) tick();
    endtask

    task automatic apply_load(input logic [15:0] b, input logic [3:0] d);
        bus.load   = 1'b1;
        bus.bcd_in = b;
        bus.dp_in  = d;
        tick();
        bus.load   = 1'b0;
    endtask

    task automatic check_off(input string tag);
        check({tag, "_an"}, 32'(bus.an), 32'hF);
        check({tag, "_seg"}, 32'(bus.seg), 32'h7F);
        check({tag, "_dp"}, 32'(bus.dp), 32'h1);
        check({tag, "_ft"}, 32'(bus.frame_tick), 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int ticks_seen;
        logic [15:0] rb;

        bus.load   = 1'b0;
        bus.bcd_in = '0;
        bus.dp_in  = '0;
        reset      = 1'b1;
        #1 reset   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_off("reset_init");
        reset = 1'b1;
        model_reset();

        // Startup: first lit digit after dead time, first frame_tick after one frame
        run(40);

        // Basic display of 1234 with dp on digit 1
        apply_load(16'h1234, 4'b0010);
        run_to(FRAME - 1);
        run(FRAME + 1);

        // Load during digit-2 slot must not tear the current frame
        run_to(2 * RD + 3);
        apply_load(16'h5678, 4'b0101);
        run_to(FRAME - 1);
        run(FRAME + 1);

        // Back-to-back loads: last one wins
        apply_load(16'h4321, 4'b1111);
        apply_load(16'h9087, 4'b1000);
        run_to(FRAME - 1);

        // Load exactly on the frame boundary shows in the very next frame
        apply_load(16'h00A0, 4'b0000);
        run(FRAME);

        // Exactly four frame_tick pulses in 128 cycles
        ticks_seen = 0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            tick();
            if (bus.frame_tick) ticks_seen++;
        end
        check("frame_tick_count", 32'(ticks_seen), 32'd4);

        // Leading-zero patterns (blanked only when the macro is defined)
        apply_load(16'h0070, 4'b1111);
        run_to(FRAME - 1);
        run(FRAME + 1);
        apply_load(16'h0000, 4'b1111);
        run_to(FRAME - 1);
        run(FRAME + 1);
        apply_load(16'hB000, 4'b0001);
        run_to(FRAME - 1);
        run(FRAME + 1);

        // Reset asserted mid digit-2 slot forces pins off at once
        apply_load(16'h1234, 4'b0110);
        run_to(FRAME - 1);
        run(1);
        run_to(2 * RD + 5);
        #2 reset = 1'b0;
        #1;
        check_off("reset_mid");
        repeat (2) @(posedge clk);
        #1;
        check_off("reset_hold");
        reset = 1'b1;
        model_reset();
        run(FRAME + 4);

        // Randomized loads, biased toward zero digits to exercise blanking
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) == 0) begin
                for (int k = 0; k < 4; k++)
                    rb[4*k +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
                apply_load(rb, 4'($urandom_range(0, 15)));
            end else begin
                tick();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
